color_mapper_pal: RTL and testbench

- Next-generation VGA colour mapper: composites NUM_LAYERS sprite/object layers over a selectable background and maps each layer's colour index through a writable RGB palette.
- Fully registered, 2-cycle pipeline between the VGA controller's pixel coordinates and the VGA DAC outputs.
- Palette is written by the game/host logic at any time, including mid-frame.

---
 rtl/color_mapper_pal.sv | 142 ++++++++++++++
 tb/tb_color_mapper_pal.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/color_mapper_pal.sv
// Two-stage VGA colour mapper: layer priority select plus background generation,
// then a writable-palette lookup. Optional output dimming via COLOR_MAPPER_PAL_BRIGHTNESS_EN.
module color_mapper_pal #(
    parameter int NUM_LAYERS = 2,
    parameter int IDX_W      = 4,
    parameter int COLOR_W    = 8,
    parameter int COORD_W    = 10
) (
    input  logic                        Clk,
    input  logic                        Reset_n,
    input  logic                        pix_valid_in,
    input  logic [COORD_W-1:0]          ReadX,
    input  logic [COORD_W-1:0]          ReadY,
    input  logic [NUM_LAYERS-1:0]       layer_hit,
    input  logic [NUM_LAYERS*IDX_W-1:0] layer_idx,
    input  logic                        pal_we,
    input  logic [IDX_W-1:0]            pal_waddr,
    input  logic [3*COLOR_W-1:0]        pal_wdata,
    input  logic [1:0]                  bg_mode,
    input  logic [3*COLOR_W-1:0]        bg_color,
`ifdef COLOR_MAPPER_PAL_BRIGHTNESS_EN
    input  logic [2:0]                  brightness,
`endif
    output logic [COLOR_W-1:0]          VGA_R,
    output logic [COLOR_W-1:0]          VGA_G,
    output logic [COLOR_W-1:0]          VGA_B,
    output logic                        pix_valid_out
);

    localparam int DEPTH = 2**IDX_W;
    localparam int SHIFT = COLOR_W - IDX_W;

    typedef logic [3*COLOR_W-1:0] rgb_t;

    rgb_t                palette [DEPTH];
    logic [COLOR_W-1:0]  frame_cnt;

    logic                s1_valid;
    logic                s1_hit;
    logic [IDX_W-1:0]    s1_idx;
    rgb_t                s1_bg;

    logic                sel_hit;
    logic [IDX_W-1:0]    sel_idx;
    rgb_t                bg_rgb;
    rgb_t                s2_rgb;
    logic                frame_start;

    // Only the upper coordinate bits feed the gradient; the rest are intentionally ignored.
    logic                unused_coord_bits;
    assign unused_coord_bits = ^{ReadX, ReadY};

    assign frame_start = pix_valid_in && (ReadX == '0) && (ReadY == '0);

    // NOTE: every always_comb output gets a default first, otherwise a missed branch infers a latch.
    always_comb begin
        sel_hit = 1'b0;
        sel_idx = '0;
        // Walk from the lowest-priority layer upwards so layer 0 overwrites last.
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (layer_hit[i]) begin
                sel_hit = 1'b1;
                sel_idx = layer_idx[i*IDX_W +: IDX_W];
            end
        end
    end

    always_comb begin
        bg_rgb = bg_color;
        case (bg_mode)
            2'd1:    bg_rgb = {ReadX[COORD_W-1 -: COLOR_W], ReadY[COORD_W-2 -: COLOR_W],
                               bg_color[COLOR_W-1:0]};
            2'd2:    bg_rgb = {bg_color[3*COLOR_W-1:COLOR_W], frame_cnt};
            default: bg_rgb = bg_color;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            s1_valid  <= 1'b0;
            s1_hit    <= 1'b0;
            s1_idx    <= '0;
            s1_bg     <= '0;
            frame_cnt <= '0;
        end else begin
            s1_valid <= pix_valid_in;
            if (pix_valid_in) begin
                s1_hit <= sel_hit;
                s1_idx <= sel_hit ? sel_idx : '0;
                s1_bg  <= sel_hit ? '0 : bg_rgb;
            end else begin
                s1_hit <= 1'b0;
                s1_idx <= '0;
                s1_bg  <= '0;
            end
            if (frame_start) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    // NOTE: the palette is reset to a grey ramp, so it is built from flops rather than a RAM macro.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                palette[i] <= {3{COLOR_W'(i << SHIFT)}};
            end
        end else if (pal_we) begin
            palette[pal_waddr] <= pal_wdata;
        end
    end

    // A lookup on the same edge as a write to that entry sees the old contents.
    always_comb begin
        s2_rgb = s1_hit ? palette[s1_idx] : s1_bg;
        if (!s1_valid) begin
            s2_rgb = '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            VGA_R         <= '0;
            VGA_G         <= '0;
            VGA_B         <= '0;
            pix_valid_out <= 1'b0;
        end else begin
`ifdef COLOR_MAPPER_PAL_BRIGHTNESS_EN
            VGA_R <= s2_rgb[3*COLOR_W-1:2*COLOR_W] >> brightness;
            VGA_G <= s2_rgb[2*COLOR_W-1:COLOR_W]   >> brightness;
            VGA_B <= s2_rgb[COLOR_W-1:0]           >> brightness;
`else
            VGA_R <= s2_rgb[3*COLOR_W-1:2*COLOR_W];
            VGA_G <= s2_rgb[2*COLOR_W-1:COLOR_W];
            VGA_B <= s2_rgb[COLOR_W-1:0];
`endif
            pix_valid_out <= s1_valid;
        end
    end

endmodule

// File: tb/tb_color_mapper_pal.sv
// Bench for color_mapper_pal: vector table plus hand-written frame-counter, reset
// and brightness sequences; expected results flow through a two-deep scoreboard queue.
module tb_color_mapper_pal;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b1;
    logic        pix_valid_in = 1'b0;
    logic [9:0]  ReadX = '0;
    logic [9:0]  ReadY = '0;
    logic [1:0]  layer_hit = '0;
    logic [7:0]  layer_idx = '0;
    logic        pal_we = 1'b0;
    logic [3:0]  pal_waddr = '0;
    logic [23:0] pal_wdata = '0;
    logic [1:0]  bg_mode = '0;
    logic [23:0] bg_color = '0;
`ifdef COLOR_MAPPER_PAL_BRIGHTNESS_EN
    logic [2:0]  brightness = '0;
`endif
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic        pix_valid_out;

    always #5 Clk = ~Clk;

    color_mapper_pal dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .pix_valid_in  (pix_valid_in),
        .ReadX         (ReadX),
        .ReadY         (ReadY),
        .layer_hit     (layer_hit),
        .layer_idx     (layer_idx),
        .pal_we        (pal_we),
        .pal_waddr     (pal_waddr),
        .pal_wdata     (pal_wdata),
        .bg_mode       (bg_mode),
        .bg_color      (bg_color),
`ifdef COLOR_MAPPER_PAL_BRIGHTNESS_EN
        .brightness    (brightness),
`endif
        .VGA_R         (VGA_R),
        .VGA_G         (VGA_G),
        .VGA_B         (VGA_B),
        .pix_valid_out (pix_valid_out)
    );

    typedef struct {
        string       name;
        logic        valid;
        logic [1:0]  hit;
        logic [3:0]  idx0;
        logic [3:0]  idx1;
        logic [1:0]  mode;
        logic [23:0] bg;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        we;
        logic [3:0]  waddr;
        logic [23:0] wdata;
        logic [24:0] exp;   // {pix_valid_out, R, G, B}
    } vec_t;

    typedef struct {
        string       name;
        logic [24:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [24:0] act, input logic [24:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got valid=%b rgb=%h, expected valid=%b rgb=%h",
                     name, act[24], act[23:0], exp[24], exp[23:0]);
        end
    endtask

    function automatic vec_t px(input string name, input logic valid, input logic [1:0] hit,
                                input logic [3:0] i0, input logic [3:0] i1,
                                input logic [1:0] mode, input logic [24:0] exp);
        vec_t v;
        v.name = name;   v.valid = valid; v.hit = hit;  v.idx0 = i0; v.idx1 = i1;
        v.mode = mode;   v.bg = 24'h123456; v.x = 10'd5; v.y = 10'd5;
        v.we = 1'b0;     v.waddr = '0;    v.wdata = '0; v.exp = exp;
        return v;
    endfunction

    function automatic vec_t wr(input string name, input logic [3:0] a, input logic [23:0] d);
        vec_t v;
        v = px(name, 1'b0, 2'b00, 4'h0, 4'h0, 2'd0, 25'h0);
        v.we = 1'b1; v.waddr = a; v.wdata = d;
        return v;
    endfunction

    // Drive one pixel, push its expectation, and compare the pixel driven one call earlier.
    task automatic apply(input vec_t v);
        exp_t e;
        pix_valid_in = v.valid;
        layer_hit    = v.hit;
        layer_idx    = {v.idx1, v.idx0};
        bg_mode      = v.mode;
        bg_color     = v.bg;
        ReadX        = v.x;
        ReadY        = v.y;
        pal_we       = v.we;
        pal_waddr    = v.waddr;
        pal_wdata    = v.wdata;
        sb.push_back('{v.name, v.exp});
        @(posedge Clk);
        #1;
        if (sb.size() > 1) begin
            e = sb.pop_front();
            check(e.name, {pix_valid_out, VGA_R, VGA_G, VGA_B}, e.exp);
        end
    endtask

    // Reset with busy inputs and a competing palette write; outputs must read 0 every reset cycle.
    task automatic do_reset(input int n);
        Reset_n      = 1'b0;
        pix_valid_in = 1'b1;
        layer_hit    = 2'b01;
        pal_we       = 1'b1;
        pal_waddr    = 4'hA;
        pal_wdata    = 24'hFFFFFF;
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            #1;
            check("reset_outputs", {pix_valid_out, VGA_R, VGA_G, VGA_B}, 25'h0);
        end
        Reset_n = 1'b1;
        pal_we  = 1'b0;
        sb.delete();
        sb.push_back('{"first_edge_after_reset", 25'h0});
    endtask

    vec_t tbl[$];
    vec_t v;

    initial begin
        tbl.push_back(px("reset_default", 1, 2'b01, 4'hA, 4'h0, 2'd0, {1'b1, 24'hA0A0A0}));
        tbl.push_back(wr("wr_pal3", 4'h3, 24'hFF0000));
        tbl.push_back(wr("wr_pal5", 4'h5, 24'h00FF00));
        tbl.push_back(px("prio_both", 1, 2'b11, 4'h3, 4'h5, 2'd0, {1'b1, 24'hFF0000}));
        tbl.push_back(px("prio_layer1", 1, 2'b10, 4'h3, 4'h5, 2'd0, {1'b1, 24'h00FF00}));
        tbl.push_back(px("bg_mode0", 1, 2'b00, 4'h3, 4'h5, 2'd0, {1'b1, 24'h123456}));
        tbl.push_back(px("bg_mode3", 1, 2'b00, 4'h3, 4'h5, 2'd3, {1'b1, 24'h123456}));
        v = px("bg_mode1", 1, 2'b00, 4'h0, 4'h0, 2'd1, {1'b1, 24'hA0EF56});
        v.x = 10'd640; v.y = 10'd478;
        tbl.push_back(v);
        tbl.push_back(px("bg_mode2_cnt0", 1, 2'b00, 4'h0, 4'h0, 2'd2, {1'b1, 24'h123400}));
        tbl.push_back(px("blank", 0, 2'b01, 4'hA, 4'h0, 2'd0, 25'h0));
        tbl.push_back(wr("wr_pal7_old", 4'h7, 24'h111111));
        tbl.push_back(px("collision_old", 1, 2'b01, 4'h7, 4'h0, 2'd0, {1'b1, 24'h111111}));
        v = px("collision_new", 1, 2'b01, 4'h7, 4'h0, 2'd0, {1'b1, 24'h222222});
        v.we = 1'b1; v.waddr = 4'h7; v.wdata = 24'h222222;
        tbl.push_back(v);
        tbl.push_back(wr("wr_pal7_a", 4'h7, 24'h333333));
        tbl.push_back(wr("wr_pal7_b", 4'h7, 24'h444444));
        tbl.push_back(px("last_write_wins", 1, 2'b01, 4'h7, 4'h0, 2'd0, {1'b1, 24'h444444}));

        do_reset(3);
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
        end

        // Frame counter: three frame starts, then run up to 255 and across the wrap.
        for (int i = 0; i < 3; i++) begin
            v = px("frame_start", 1, 2'b00, 4'h0, 4'h0, 2'd0, {1'b1, 24'h123456});
            v.x = '0; v.y = '0;
            apply(v);
        end
        apply(px("frame_cnt_3", 1, 2'b00, 4'h0, 4'h0, 2'd2, {1'b1, 24'h123403}));
        for (int i = 0; i < 252; i++) begin
            v = px("frame_start", 1, 2'b00, 4'h0, 4'h0, 2'd0, {1'b1, 24'h123456});
            v.x = '0; v.y = '0;
            apply(v);
        end
        apply(px("frame_cnt_255", 1, 2'b00, 4'h0, 4'h0, 2'd2, {1'b1, 24'h1234FF}));
        v = px("frame_start", 1, 2'b00, 4'h0, 4'h0, 2'd0, {1'b1, 24'h123456});
        v.x = '0; v.y = '0;
        apply(v);
        apply(px("frame_cnt_wrap", 1, 2'b00, 4'h0, 4'h0, 2'd2, {1'b1, 24'h123400}));

        // Mid-stream reset: pending pixel is flushed and palette returns to the grey ramp.
        apply(px("pre_reset", 1, 2'b01, 4'h3, 4'h0, 2'd0, {1'b1, 24'hFF0000}));
        do_reset(1);
        apply(px("grey_ramp_3", 1, 2'b01, 4'h3, 4'h0, 2'd0, {1'b1, 24'h303030}));
        apply(px("grey_ramp_7", 1, 2'b01, 4'h7, 4'h0, 2'd0, {1'b1, 24'h707070}));
        apply(px("grey_ramp_A", 1, 2'b01, 4'hA, 4'h0, 2'd0, {1'b1, 24'hA0A0A0}));

`ifdef COLOR_MAPPER_PAL_BRIGHTNESS_EN
        apply(wr("wr_pal9", 4'h9, 24'hFF8040));
        brightness = 3'd2;
        apply(px("bright_2", 1, 2'b01, 4'h9, 4'h0, 2'd0, {1'b1, 24'h3F2010}));
        apply(px("bright_0", 1, 2'b01, 4'h9, 4'h0, 2'd0, {1'b1, 24'hFF8040}));
        brightness = 3'd0;
`endif
        apply(px("idle", 0, 2'b00, 4'h0, 4'h0, 2'd0, 25'h0));
        apply(px("idle", 0, 2'b00, 4'h0, 4'h0, 2'd0, 25'h0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
